// File: rtl/disp_arbiter.sv
// disp_arbiter: round-robin sharing of the 4-digit display between three sources with a fixed dwell per grant.
// Optional leading-zero blanking output when DISP_ARBITER_LZB_EN is defined.
module disp_arbiter #(
    parameter int PRESCALE = 48000,
    parameter int HOLD_MS  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [15:0] val2,
    output logic [3:0]  num1,
    output logic [3:0]  num2,
    output logic [3:0]  num3,
    output logic [3:0]  num4,
    output logic [1:0]  src,
    output logic        busy,
    output logic [2:0]  grant
`ifdef DISP_ARBITER_LZB_EN
    ,output logic [3:0] blank
`endif
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int TW = HOLD_MS > 1 ? $clog2(HOLD_MS) : 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state_q;
    logic [2:0]      pending_q, pending_d, grant_q, grant_d;
    logic [1:0]      rr_q, src_q, n0, n1, n2, pick_idx;
    logic [PW-1:0]   pre_q;
    logic [TW-1:0]   tick_q;
    logic [15:0]     val_q, sel_val;
    logic            pre_wrap, done, go;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return x == 2'd2 ? 2'd0 : x + 2'd1;
    endfunction

    // Round-robin pick from the slot after the last grant, dwell-end detection and pending update with absorb.
    always_comb begin
        n0        = inc3(rr_q);
        n1        = inc3(n0);
        n2        = inc3(n1);
        pick_idx  = pending_q[n0] ? n0 : pending_q[n1] ? n1 : n2;
        pre_wrap  = pre_q == PW'(PRESCALE - 1);
        done      = pre_wrap && tick_q == TW'(HOLD_MS - 1);
        go        = |pending_q && (state_q == IDLE || done);
        grant_d   = go ? 3'b001 << pick_idx : 3'b000;
        pending_d = (pending_q | req) & ~grant_d & ~grant_q;
        sel_val   = grant_q[0] ? val0 : grant_q[1] ? val1 : val2;
    end

    // Grant/dwell FSM; the value of a granted source is captured the cycle after its grant pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            rr_q      <= 2'd2;
            pre_q     <= '0;
            tick_q    <= '0;
            val_q     <= '0;
            src_q     <= 2'd3;
        end else begin
            pending_q <= pending_d;
            grant_q   <= grant_d;
            if (go) begin
                state_q <= HOLD;
                rr_q    <= pick_idx;
                pre_q   <= '0;
                tick_q  <= '0;
            end else if (state_q == HOLD) begin
                if (done) begin
                    state_q <= IDLE;
                    pre_q   <= '0;
                    tick_q  <= '0;
                end else begin
                    pre_q  <= pre_wrap ? '0 : pre_q + PW'(1);
                    tick_q <= pre_wrap ? tick_q + TW'(1) : tick_q;
                end
            end
            if (|grant_q) begin
                val_q <= sel_val;
                src_q <= grant_q[0] ? 2'd0 : grant_q[1] ? 2'd1 : 2'd2;
            end
        end
    end

`ifdef DISP_ARBITER_LZB_EN
    logic [3:0] blank_q;

    // Blank flags track the captured value: a digit is blank when it and all higher digits are zero.
    always_ff @(posedge clk) begin
        if (rst) blank_q <= 4'b1110;
        else if (|grant_q) blank_q <= {sel_val[15:12] == 4'd0, sel_val[15:8] == 8'd0, sel_val[15:4] == 12'd0, 1'b0};
    end

    assign blank = blank_q;
`endif

    assign num1  = val_q[3:0];
    assign num2  = val_q[7:4];
    assign num3  = val_q[11:8];
    assign num4  = val_q[15:12];
    assign src   = src_q;
    assign busy  = state_q == HOLD;
    assign grant = grant_q;
endmodule

// File: doc/disp_arbiter.md
Name: disp_arbiter

Overview:
- Shares the 4-digit seven-segment display (dt_module num1..num4 inputs) between three value sources, e.g. IR code, ADC sample and key counter.
- Each source raises a one-cycle update strobe. The arbiter grants one source at a time in round-robin order and holds its captured value on the display for a fixed dwell time, then moves to the next pending source.
- Sits between the source modules and dt_module in top, replacing direct num_dt assignments.

Parameters:
- PRESCALE, 48000, clk cycles per dwell tick (1 ms at 48 MHz); must be >= 1.
- HOLD_MS, 1000, dwell length in ticks per grant; must be >= 1.

Ports:
- clk  in  1  system clock (48 MHz CLK).
- rst  in  1  synchronous reset, active-high.
- req  in  3  per-source update strobe, bit i = source i, one-cycle pulse.
- val0  in  16  source 0 value.
- val1  in  16  source 1 value.
- val2  in  16  source 2 value.
- num1  out  4  displayed digit 1 = captured value[3:0].
- num2  out  4  captured value[7:4].
- num3  out  4  captured value[11:8].
- num4  out  4  captured value[15:12].
- src  out  2  source currently shown: 0..2; 3 = none since reset.
- busy  out  1  high while a dwell is in progress.
- grant  out  3  one-hot, one-cycle pulse when a source is accepted.

Behaviour:
- Reset (synchronous, rst high at clk edge): num1..num4=0, src=3, busy=0, grant=0, pending=0, prescaler=0, tick counter=0, RR pointer=2 (so the first search starts at source 0), state IDLE. Reset mid-dwell aborts immediately; no grant is issued in the reset cycle.
- pending[2:0] register:
  - req[i] sampled at an edge sets pending[i].
  - A grant of source i clears pending[i].
  - If req[i] arrives in the same cycle as grant[i], the req is absorbed and pending[i] ends cleared.
- Round-robin pick: the first set pending bit searching from (last granted + 1) mod 3 upward with wrap.
- States:
  - IDLE: busy=0. If pending != 0, assert grant for the picked source this cycle, capture that source's val, set src, and go to HOLD. Otherwise stay in IDLE; the display keeps its last value.
  - HOLD: busy=1. The prescaler counts 0..PRESCALE-1 and wraps with a tick; ticks are counted 0..HOLD_MS-1.
  - HOLD, on the tick that completes HOLD_MS: if pending != 0, grant the next RR source in that same cycle, restart prescaler and tick counter, and stay in HOLD. Otherwise go to IDLE.
- Timing:
  - Prescaler and tick counter reset to 0 at every grant. A dwell therefore lasts exactly PRESCALE*HOLD_MS cycles from grant to the next possible grant or to busy falling.
  - Latency: req at edge n → grant high in cycle n+1 → num/src updated at edge n+1+1 (visible cycle n+2).
- Captured value is frozen for the whole dwell; changes on valN without req are not shown.
- A source that re-requests during its own dwell is re-granted only per RR order.
- All counters are sized for their parameter maximum and wrap only as specified.

Optional Feature:
- Macro: DISP_ARBITER_LZB_EN.
- Defined: adds output blank[3:0], registered and updated together with num.
  - blank[k] (k=1..3) is high when digit k+1 and every more significant digit are zero.
  - blank[0] is always 0.
  - Reset value is 4'b1110.
- Undefined: blank port and its logic are absent.

Test Plan:
- Reset: assert rst 3 cycles during an active dwell → num1..4=0, src=3, busy=0, grant=0 from the first post-reset cycle; no grant until a new req.
- Single request (PRESCALE=4, HOLD_MS=3): req=3'b010, val1=16'h1234 at edge 10 → grant=3'b010 in cycle 11; num4..num1=1,2,3,4 and src=1 from cycle 12; busy falls exactly 12 cycles after the grant cycle.
- Simultaneous requests: req=3'b111 once → grants 0,1,2 at 12-cycle intervals, then IDLE with src=2 and the display holding val2.
- RR fairness: req[0] pulsed every dwell while req[2] is pending → grant order 0,2,0,2; source 1 never granted without its own req.
- Frozen value and absorb: change val1 mid-dwell without req → display unchanged. req[1] in the grant cycle of source 1 → no second grant of source 1.
- DISP_ARBITER_LZB_EN: captured 16'h0050 → blank=4'b1100; 16'h0000 → blank=4'b1110; 16'h8000 → blank=4'b0000.
